spi_slave_core: RTL

Synchronous SPI peripheral (slave) endpoint for the UART-to-SPI bridge: the responder-side counterpart of the bridge's SPI master engine. It oversamples the external SCK/SS/MOSI pins with `sys_clk`, deserializes MOSI into words of 1–16 bits and serializes a queued transmit word onto MISO. It exposes valid/ready-style register handshakes to the fabric and is used both as a loop-back test target for the master and as the bridge's slave-mode front end.

---
 rtl/spi_slave_core.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_core.sv
// SPI slave endpoint: oversamples SCK/SS/MOSI, deserializes 1-16 bit words and serializes a queued transmit word.
// Latency: SYNC_STAGES+1 cycles from pin to action. Backpressure: none on the wire; tx is a one-deep holding register and rx is overwritten, both flagged sticky.
module spi_slave_core #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [3:0]  word_length,
   input  logic        lsb_first,
   input  logic        sample_rising,
   input  logic        spi_sck,
   input  logic        spi_ss_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        miso_oe,
   input  logic [15:0] tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [15:0] rx_data,
   output logic        rx_valid,
   input  logic        rx_ack,
   output logic        rx_overrun,
   output logic        tx_underrun
);

   typedef enum logic [1:0] {IDLE, SHIFT, DELIVER} state_t;

   logic [SYNC_STAGES-1:0] sck_pipe, ss_pipe, mosi_pipe;
   logic                   sck_hist, ss_hist;
   logic                   sck_s, ss_s, mosi_s;

   state_t      state, state_nxt;
   logic [3:0]  cfg_wl, cfg_wl_nxt;
   logic        cfg_lsb, cfg_lsb_nxt;
   logic        cfg_rise, cfg_rise_nxt;
   logic [3:0]  bitno, bitno_nxt;
   logic [15:0] rx_shift, rx_shift_nxt;
   logic [15:0] tx_shift, tx_shift_nxt;
   logic        hold_full, hold_full_nxt;
   logic [15:0] hold_data, hold_data_nxt;
   logic        miso_nxt, oe_nxt;
   logic [15:0] rx_data_nxt;
   logic        rx_valid_nxt, ovr_nxt, unr_nxt;

   logic        sck_edge, sample_edge, drive_edge, ss_fall, ss_rise;
   logic        word_start, start_lsb;
   logic [3:0]  start_wl, drive_idx;
   logic [15:0] start_word, wl_mask;

   assign sck_s  = sck_pipe[SYNC_STAGES-1];
   assign ss_s   = ss_pipe[SYNC_STAGES-1];
   assign mosi_s = mosi_pipe[SYNC_STAGES-1];

   assign sck_edge    = sck_s != sck_hist;
   assign sample_edge = sck_edge && (sck_s == cfg_rise);
   assign drive_edge  = sck_edge && (sck_s != cfg_rise);
   assign ss_fall     = ss_hist && !ss_s;
   assign ss_rise     = !ss_hist && ss_s;

   assign drive_idx = cfg_lsb ? bitno : (cfg_wl - bitno);
   assign wl_mask   = 16'hFFFF >> (4'd15 - cfg_wl);
   assign tx_ready  = !hold_full;

   always_comb begin
      state_nxt     = state;
      cfg_wl_nxt    = cfg_wl;
      cfg_lsb_nxt   = cfg_lsb;
      cfg_rise_nxt  = cfg_rise;
      bitno_nxt     = bitno;
      rx_shift_nxt  = rx_shift;
      tx_shift_nxt  = tx_shift;
      hold_full_nxt = hold_full;
      hold_data_nxt = hold_data;
      miso_nxt      = spi_miso;
      oe_nxt        = miso_oe;
      rx_data_nxt   = rx_data;
      rx_valid_nxt  = rx_valid;
      ovr_nxt       = rx_overrun;
      unr_nxt       = tx_underrun;
      word_start    = 1'b0;
      start_wl      = cfg_wl;
      start_lsb     = cfg_lsb;
      start_word    = '0;

      if (tx_valid && !hold_full) begin
         hold_full_nxt = 1'b1;
         hold_data_nxt = tx_data;
      end
      if (rx_ack && rx_valid) begin
         rx_valid_nxt = 1'b0;
      end

      if (ss_rise) begin
         state_nxt    = IDLE;
         bitno_nxt    = '0;
         oe_nxt       = 1'b0;
         rx_shift_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (ss_fall) begin
                  cfg_wl_nxt   = word_length;
                  cfg_lsb_nxt  = lsb_first;
                  cfg_rise_nxt = sample_rising;
                  start_wl     = word_length;
                  start_lsb    = lsb_first;
                  word_start   = 1'b1;
                  oe_nxt       = 1'b1;
                  rx_shift_nxt = '0;
                  state_nxt    = SHIFT;
               end
            end
            SHIFT: begin
               if (sample_edge) begin
                  if (cfg_lsb) rx_shift_nxt[bitno] = mosi_s;
                  else         rx_shift_nxt = {rx_shift[14:0], mosi_s};
                  bitno_nxt = bitno + 4'd1;
                  if (bitno == cfg_wl) state_nxt = DELIVER;
               end else if (drive_edge && bitno != 4'd0) begin
                  // bit 0 is already on the wire from the word start
                  miso_nxt = tx_shift[drive_idx];
               end
            end
            DELIVER: begin
               rx_data_nxt  = rx_shift & wl_mask;
               rx_valid_nxt = 1'b1;
               if (rx_valid && !rx_ack) ovr_nxt = 1'b1;
               rx_shift_nxt = '0;
               word_start   = 1'b1;
               state_nxt    = SHIFT;
            end
            default: state_nxt = IDLE;
         endcase
      end

      if (word_start) begin
         start_word   = hold_full ? hold_data : 16'h0000;
         tx_shift_nxt = start_word;
         bitno_nxt    = '0;
         miso_nxt     = start_word[start_lsb ? 4'd0 : start_wl];
         if (hold_full) hold_full_nxt = 1'b0;
         else           unr_nxt = 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sck_pipe    <= '1;
         ss_pipe     <= '1;
         mosi_pipe   <= '0;
         sck_hist    <= 1'b1;
         ss_hist     <= 1'b1;
         state       <= IDLE;
         cfg_wl      <= '0;
         cfg_lsb     <= 1'b0;
         cfg_rise    <= 1'b0;
         bitno       <= '0;
         rx_shift    <= '0;
         tx_shift    <= '0;
         hold_full   <= 1'b0;
         hold_data   <= '0;
         spi_miso    <= 1'b0;
         miso_oe     <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         rx_overrun  <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         sck_pipe    <= {sck_pipe[SYNC_STAGES-2:0], spi_sck};
         ss_pipe     <= {ss_pipe[SYNC_STAGES-2:0], spi_ss_n};
         mosi_pipe   <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
         sck_hist    <= sck_s;
         ss_hist     <= ss_s;
         state       <= state_nxt;
         cfg_wl      <= cfg_wl_nxt;
         cfg_lsb     <= cfg_lsb_nxt;
         cfg_rise    <= cfg_rise_nxt;
         bitno       <= bitno_nxt;
         rx_shift    <= rx_shift_nxt;
         tx_shift    <= tx_shift_nxt;
         hold_full   <= hold_full_nxt;
         hold_data   <= hold_data_nxt;
         spi_miso    <= miso_nxt;
         miso_oe     <= oe_nxt;
         rx_data     <= rx_data_nxt;
         rx_valid    <= rx_valid_nxt;
         rx_overrun  <= ovr_nxt;
         tx_underrun <= unr_nxt;
      end
   end

endmodule
